// File: rtl/rpn_key_frontend.sv
// rpn_key_frontend: conditions the raw KEY/SW inputs of the RPN calculator.
// Synchronises and debounces the keys, turns each clean single-key press into
// one {mode, keycode} + switch-value command, and hands it to the core over
// a valid/ready handshake.
//
// FSM states:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | no command pending, waiting for a clean single-key press
//   PEND     | command presented on cmd_*, waiting for cmd_ready
//   WAIT_REL | command delivered (or reset seen), waiting for all keys up
module rpn_key_frontend #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key,
    input  logic [1:0]  mode,
    input  logic [15:0] val,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [3:0]  cmd_op,
    output logic [15:0] cmd_val,
    output logic [3:0]  key_state,
    output logic        cmd_drop
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       key_s1, key_s2;
    logic [1:0]       mode_s1, mode_s2;
    logic [15:0]      val_s1, val_s2;
    logic [3:0]       deb, deb_q;
    logic [CNT_W-1:0] cnt [4];

    state_t state, state_nxt;
    logic   load_cmd, drop_nxt;
    logic   press_any, one_low;
    logic [1:0] keycode;

    // Two-flop synchronisers; keys reset to 0 so they read as pressed until
    // they debounce to released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_s1  <= '0;
            key_s2  <= '0;
            mode_s1 <= '0;
            mode_s2 <= '0;
            val_s1  <= '0;
            val_s2  <= '0;
        end else begin
            key_s1  <= key;
            key_s2  <= key_s1;
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            val_s1  <= val;
            val_s2  <= val_s1;
        end
    end

    // Per-key debounce: a key must disagree with its debounced value for
    // DEBOUNCE_CYCLES consecutive cycles before the debounced value follows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb[i] <= key_s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign key_state = ~deb;
    assign press_any = |(deb_q & ~deb);
    assign one_low   = $onehot(~deb);

    // Keycode of the single key currently held down.
    always_comb begin
        keycode = 2'b00;
        case (deb)
            4'b0111: keycode = 2'b11;
            4'b1011: keycode = 2'b10;
            4'b1101: keycode = 2'b01;
            default: keycode = 2'b00;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT_REL;
        else      state <= state_nxt;
    end

    // Next-state logic, command load and drop decisions.
    always_comb begin
        state_nxt = state;
        load_cmd  = 1'b0;
        drop_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (press_any) begin
                    if (one_low) begin
                        load_cmd  = 1'b1;
                        state_nxt = PEND;
                    end else begin
                        drop_nxt = 1'b1;
                    end
                end
            end
            PEND: begin
                // A second press before the first is accepted is lost.
                if (press_any) drop_nxt = 1'b1;
                if (cmd_ready) state_nxt = WAIT_REL;
            end
            WAIT_REL: begin
                if (deb == 4'hF) state_nxt = IDLE;
            end
            default: state_nxt = WAIT_REL;
        endcase
    end

    // Registered command outputs; op/val are frozen while pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_val   <= '0;
            cmd_drop  <= 1'b0;
        end else begin
            cmd_valid <= (state_nxt == PEND);
            cmd_drop  <= drop_nxt;
            if (load_cmd) begin
                cmd_op  <= {mode_s2, keycode};
                cmd_val <= val_s2;
            end
        end
    end

endmodule

// File: tb/tb_rpn_key_frontend.sv
// Testbench for rpn_key_frontend with DEBOUNCE_CYCLES=4. Stimulus pushes the
// expected commands and drop pulses; a monitor pops and checks them as the
// DUT presents them.
module tb_rpn_key_frontend;

    logic        clk;
    logic        rst;
    logic [3:0]  key;
    logic [1:0]  mode;
    logic [15:0] val;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_val;
    logic [3:0]  key_state;
    logic        cmd_drop;

    int checks   = 0;
    int failures = 0;
    int exp_drops = 0;
    logic [19:0] sb [$];

    rpn_key_frontend #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .mode      (mode),
        .val       (val),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_val   (cmd_val),
        .key_state (key_state),
        .cmd_drop  (cmd_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Monitor: samples between edges, after stimulus has settled.
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                if (cmd_valid && cmd_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_cmd: got op=0x%0h val=0x%0h expected none",
                                 cmd_op, cmd_val);
                    end else begin
                        e = sb.pop_front();
                        if ({cmd_op, cmd_val} !== e) begin
                            failures++;
                            $display("FAIL cmd_xfer: got op=0x%0h val=0x%0h expected op=0x%0h val=0x%0h",
                                     cmd_op, cmd_val, e[19:16], e[15:0]);
                        end
                    end
                end
                if (cmd_drop) begin
                    checks++;
                    if (exp_drops == 0) begin
                        failures++;
                        $display("FAIL unexpected_drop: got cmd_drop=1 expected 0");
                    end else begin
                        exp_drops--;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b0; key = 4'hF; mode = 2'b00; val = 16'h0; cmd_ready = 1'b0;

        // Reset state
        cycles(3);
        check("rst_key_state", key_state, 4'hF);
        check("rst_valid", cmd_valid, 1'b0);
        check("rst_op", cmd_op, 4'h0);
        check("rst_val", cmd_val, 16'h0);
        check("rst_drop", cmd_drop, 1'b0);
        rst = 1'b1;
        cycles(5);
        check("rel_key_state_e5", key_state, 4'hF);
        cycles(1);
        check("rel_key_state_e6", key_state, 4'h0);
        cycles(50);

        // key[3] clean press, exact latency and one-cycle transfer
        cmd_ready = 1'b1; mode = 2'b00; val = 16'h1234;
        sb.push_back({4'b0011, 16'h1234});
        key = 4'b0111;
        cycles(6);
        check("k3_valid_e6", cmd_valid, 1'b0);
        cycles(1);
        check("k3_valid_e7", cmd_valid, 1'b1);
        check("k3_op_e7", cmd_op, 4'b0011);
        check("k3_val_e7", cmd_val, 16'h1234);
        cycles(1);
        check("k3_valid_e8", cmd_valid, 1'b0);
        cycles(20);
        key = 4'hF;
        cycles(10);
        sb.push_back({4'b0011, 16'h1234});
        key = 4'b0111;
        cycles(12);
        key = 4'hF;
        cycles(10);

        // key[2] bouncing then held
        mode = 2'b01; val = 16'hBEEF;
        for (int c = 0; c < 12; c++) begin
            key = (((c / 2) % 2) == 0) ? 4'b1011 : 4'hF;
            cycles(1);
        end
        check("bounce_no_valid", cmd_valid, 1'b0);
        sb.push_back({4'b0110, 16'hBEEF});
        key = 4'b1011;
        cycles(12);
        key = 4'hF;
        cycles(10);

        // key[0] with back-pressure; switches change while pending
        cmd_ready = 1'b0; mode = 2'b11; val = 16'h00A5;
        sb.push_back({4'b1100, 16'h00A5});
        key = 4'b1110;
        cycles(10);
        val = 16'hFFFF; mode = 2'b00;
        check("bp_valid_c10", cmd_valid, 1'b1);
        cycles(10);
        check("bp_valid_c20", cmd_valid, 1'b1);
        check("bp_op_c20", cmd_op, 4'b1100);
        check("bp_val_c20", cmd_val, 16'h00A5);
        cycles(5);
        check("bp_valid_c25", cmd_valid, 1'b1);
        cmd_ready = 1'b1;
        cycles(1);
        check("bp_valid_c26", cmd_valid, 1'b0);
        key = 4'hF;
        cycles(10);

        // Simultaneous key[1]+key[0]: dropped
        exp_drops++;
        key = 4'b1100;
        cycles(12);
        check("multi_no_valid", cmd_valid, 1'b0);
        key = 4'hF;
        cycles(10);
        check("multi_drop_seen", exp_drops, 0);

        // Reset while pending; key[3] held through reset
        cmd_ready = 1'b0; mode = 2'b10; val = 16'h5A5A;
        sb.push_back({4'b1011, 16'h5A5A});
        key = 4'b0111;
        cycles(9);
        check("pend_valid", cmd_valid, 1'b1);
        rst = 1'b0;
        sb.delete();
        #1;
        check("rst_async_valid", cmd_valid, 1'b0);
        cycles(2);
        rst = 1'b1;
        cmd_ready = 1'b1;
        cycles(20);
        check("held_no_valid", cmd_valid, 1'b0);
        key = 4'hF;
        cycles(10);
        sb.push_back({4'b1011, 16'h5A5A});
        key = 4'b0111;
        cycles(12);
        key = 4'hF;
        cycles(10);

        check("sb_empty", sb.size(), 0);
        check("drops_empty", exp_drops, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rpn_key_frontend.md
Name: rpn_key_frontend

Overview:
- Input-conditioning stage directly upstream of the RPN calculator core.
- Takes the raw active-low KEY[3:0] pushbuttons and the SW17..SW0 switches. It synchronises and debounces them and detects one clean press.
- Each press becomes one command: an encoded op plus the 16-bit switch value, captured at the press.
- The command is handed downstream over a valid/ready handshake, so the core sees exactly one command per physical press, even while it is busy in a multi-cycle pop/push sequence.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive cycles a synchronised key must differ from its debounced state before that state flips (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
CNT_W, 20, width of each per-key debounce counter.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
key  in  4  raw KEY[3:0], active-low (0 = pressed), asynchronous to clk.
mode  in  2  raw SW17..SW16, asynchronous.
val  in  16  raw SW15..SW0, asynchronous.
cmd_ready  in  1  downstream can accept a command this cycle.
cmd_valid  out  1  command pending on cmd_op/cmd_val.
cmd_op  out  4  {mode, keycode}; keycode: key[3]=2'b11, key[2]=2'b10, key[1]=2'b01, key[0]=2'b00.
cmd_val  out  16  switch value captured at the press.
key_state  out  4  debounced keys, active-high (1 = pressed).
cmd_drop  out  1  one-cycle pulse when a press is discarded.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst.
- Reset values:
  - cmd_valid=0, cmd_op=0, cmd_val=0, cmd_drop=0.
  - key sync flops and debounced state = 0 (pressed), so key_state=4'hF.
  - All counters 0; FSM in WAIT_REL.
  - Any pending command is discarded when reset asserts mid-operation.
  - cmd_valid falls asynchronously with rst.
- Synchronisers: 2-flop synchroniser on every key, mode and val bit. mode/val sync flops reset to 0.
- Debounce, per key:
  - If synced != debounced, the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the key still differs, debounced takes the synced value and the counter returns to 0.
  - Any cycle with synced == debounced clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Press event: a debounced 1->0 transition on a key, detected against a one-cycle-delayed copy of the debounced state.
  - Valid only if exactly one debounced key is low in that cycle.
  - Simultaneous or overlapping presses give no command and pulse cmd_drop.
- FSM states:
  - IDLE: on a valid press event, register cmd_op={mode_sync, keycode} and cmd_val=val_sync; set cmd_valid=1; go to PEND.
  - PEND: cmd_valid held at 1; cmd_op/cmd_val held stable regardless of switch changes. Transfer occurs on a clock edge with cmd_valid&cmd_ready. Then cmd_valid=0 and go to WAIT_REL.
  - WAIT_REL: stay until debounced state == 4'hF (all released), then go to IDLE.
- Event handling outside IDLE:
  - A valid press event in PEND (first key released, new key pressed before accept) is discarded with a cmd_drop pulse.
  - Press events in WAIT_REL are ignored silently.
- cmd_ready is ignored when cmd_valid=0. A transfer with cmd_ready held high costs exactly one cycle of cmd_valid.
- Latency (raw key held low and stable from edge 0):
  - Debounced state flips at edge DEBOUNCE_CYCLES+2.
  - cmd_valid rises at edge DEBOUNCE_CYCLES+3.
- After reset, keys are seen as pressed until they debounce to released (DEBOUNCE_CYCLES+2 edges). A key held through reset therefore never produces a command until it is released and pressed again.
- key_state is the inverted debounced state, updated with no further delay.
- No combinational path from any input to any output.

Test Plan:
All tests use DEBOUNCE_CYCLES=4.
- Reset release with key=4'hF: key_state reads 4'hF, then 4'h0 after edge 6; no cmd_valid or cmd_drop for 50 cycles.
- key[3] driven low cleanly with mode=00, val=0x1234, cmd_ready=1: cmd_valid high for exactly one cycle after edge 7, with cmd_op=4'b0011 and cmd_val=0x1234; no second command while held; after release, key[3] again gives one more command.
- key[2] toggled every 2 cycles for 12 cycles, then held low with mode=01: exactly one command, cmd_op=4'b0110, and zero commands during the bounce.
- key[0] pressed with mode=11, val=0x00A5, cmd_ready=0; val then changed to 0xFFFF: cmd_valid stays 1 with cmd_op=4'b1100 and cmd_val=0x00A5; cmd_ready raised at cycle 25 gives cmd_valid=0 the next cycle.
- key[1] and key[0] pressed in the same cycle: no cmd_valid; cmd_drop pulses for exactly one cycle.
- rst asserted while in PEND: cmd_valid drops immediately. After release with key[3] still held low: no command; after release then re-press, one command appears.
